imuldiv_int_div_iterative_param: RTL

Parametrised iterative integer divider: the width-generic successor to the fixed 32-bit iterative divide unit in the `imuldiv` block. It computes quotient and remainder for signed and unsigned operands using one radix-2 restoring step per cycle. It defines RISC-V-style divide-by-zero and overflow results. It optionally completes trivial divisions in a single cycle. Requests and responses use val/rdy handshakes, so it drops into the existing test-source/test-sink harness and the muldiv dispatch path.

---
 rtl/imuldiv_int_div_iterative_param.sv | 120 ++++++++++++
 1 files changed

// File: rtl/imuldiv_int_div_iterative_param.sv
// Iterative radix-2 restoring divider, signed/unsigned, val/rdy handshakes.
// Optional single-cycle completion of trivial divisions: IMULDIV_DIV_EARLY_EXIT_EN.
module imuldiv_int_div_iterative_param #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               divreq_msg_fn,
  input  logic [WIDTH-1:0]   divreq_msg_a,
  input  logic [WIDTH-1:0]   divreq_msg_b,
  input  logic               divreq_val,
  output logic               divreq_rdy,
  output logic [2*WIDTH-1:0] divresp_msg_result,
  output logic               divresp_val,
  input  logic               divresp_rdy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   rem_q, rem_d, quot_q, quot_d, b_mag_q;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               fn_q, sign_a_q, sign_q, dbz_q;

  logic               accept, a_neg, b_neg, b_zero, step_ok;
  logic [WIDTH-1:0]   a_mag, b_mag, rem_step, quot_step, rem_fix, quot_fix;
  logic [WIDTH:0]     upper, diff;

  assign accept = (state_q == StIdle) && divreq_val;
  assign a_neg  = divreq_msg_fn & divreq_msg_a[WIDTH-1];
  assign b_neg  = divreq_msg_fn & divreq_msg_b[WIDTH-1];
  assign a_mag  = a_neg ? -divreq_msg_a : divreq_msg_a;
  assign b_mag  = b_neg ? -divreq_msg_b : divreq_msg_b;
  assign b_zero = (divreq_msg_b == '0);

  // One restoring step on the shifted {rem, quot} pair.
  assign upper     = {rem_q, quot_q[WIDTH-1]};
  assign diff      = upper - {1'b0, b_mag_q};
  assign step_ok   = ~diff[WIDTH];
  assign rem_step  = step_ok ? diff[WIDTH-1:0] : upper[WIDTH-1:0];
  assign quot_step = {quot_q[WIDTH-2:0], step_ok};

  // Divide-by-zero leaves rem=|a|, so only the quotient needs overriding.
  assign rem_fix  = (fn_q & sign_a_q) ? -rem_step : rem_step;
  assign quot_fix = dbz_q ? '1 : ((fn_q & sign_q) ? -quot_step : quot_step);

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    count_d  = count_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (divreq_val) begin
          rem_d   = '0;
          quot_d  = a_mag;
          count_d = CW'(WIDTH);
          state_d = StCalc;
`ifdef IMULDIV_DIV_EARLY_EXIT_EN
          if (b_zero || (a_mag < b_mag)) begin
            state_d  = StDone;
            count_d  = '0;
            result_d = {divreq_msg_a, {WIDTH{b_zero}}};
          end
`endif
        end
      end
      StCalc: begin
        rem_d   = rem_step;
        quot_d  = quot_step;
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d  = StDone;
          result_d = {rem_fix, quot_fix};
        end
      end
      StDone: begin
        if (divresp_rdy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      rem_q    <= '0;
      quot_q   <= '0;
      count_q  <= '0;
      result_q <= '0;
      b_mag_q  <= '0;
      fn_q     <= 1'b0;
      sign_a_q <= 1'b0;
      sign_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      count_q  <= count_d;
      result_q <= result_d;
      if (accept) begin
        b_mag_q  <= b_mag;
        fn_q     <= divreq_msg_fn;
        sign_a_q <= divreq_msg_a[WIDTH-1];
        sign_q   <= divreq_msg_a[WIDTH-1] ^ divreq_msg_b[WIDTH-1];
        dbz_q    <= b_zero;
      end
    end
  end

  assign divreq_rdy         = (state_q == StIdle);
  assign divresp_val        = (state_q == StDone);
  assign divresp_msg_result = result_q;

endmodule
